// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types and encodings for the EX-stage controller
// Thumb-subset opcode match patterns, FSM states, ALU selects and ARM condition codes.
package cpu_pkg;

    typedef enum logic [1:0] {
        S_EXEC,
        S_MEM_WAIT,
        S_FLUSH
    } state_e;

    typedef enum logic [2:0] {
        ALU_NONE,
        ALU_ADD,
        ALU_SUB,
        ALU_MOV,
        ALU_CMP
    } alu_sel_e;

    typedef enum logic [3:0] {
        I_NOP,
        I_ADD,
        I_SUB_SP,
        I_MOV_IMM,
        I_MOV_REG,
        I_LDR,
        I_STR,
        I_B,
        I_BCOND,
        I_CMP_IMM
    } instr_e;

    localparam logic [6:0] OP_ADD     = 7'b0001110;
    localparam logic [8:0] OP_SUB_SP  = 9'b101100001;
    localparam logic [4:0] OP_MOV_IMM = 5'b00100;
    localparam logic [7:0] OP_MOV_REG = 8'b01000110;
    localparam logic [4:0] OP_LDR     = 5'b01101;
    localparam logic [4:0] OP_STR     = 5'b01100;
    localparam logic [4:0] OP_B       = 5'b11100;
    localparam logic [3:0] OP_BCOND   = 4'b1101;
    localparam logic [4:0] OP_CMP_IMM = 5'b00101;

    localparam logic [3:0] SP_IDX = 4'd13;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;

    // Classifies an instruction from its top nine bits (ir[15:7]).
    function automatic instr_e decode(input logic [8:0] hi);
        instr_e ins;
        ins = I_NOP;
        if (hi[8:2] == OP_ADD)          ins = I_ADD;
        else if (hi == OP_SUB_SP)       ins = I_SUB_SP;
        else if (hi[8:4] == OP_MOV_IMM) ins = I_MOV_IMM;
        else if (hi[8:1] == OP_MOV_REG) ins = I_MOV_REG;
        else if (hi[8:4] == OP_LDR)     ins = I_LDR;
        else if (hi[8:4] == OP_STR)     ins = I_STR;
        else if (hi[8:4] == OP_B)       ins = I_B;
        else if (hi[8:5] == OP_BCOND)   ins = I_BCOND;
        else if (hi[8:4] == OP_CMP_IMM) ins = I_CMP_IMM;
        return ins;
    endfunction

endpackage

// File: rtl/cond_eval.sv
// rtl/cond_eval.sv - ARM condition-code evaluation against {N,Z,C,V}
// Codes 1110 and 1111 are treated as never taken.
module cond_eval
    import cpu_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       taken
);

    logic n, z, c, v;

    assign n = flags[3];
    assign z = flags[2];
    assign c = flags[1];
    assign v = flags[0];

    always_comb begin
        taken = 1'b0;
        case (cond)
            COND_EQ: taken = z;
            COND_NE: taken = ~z;
            COND_CS: taken = c;
            COND_CC: taken = ~c;
            COND_MI: taken = n;
            COND_PL: taken = ~n;
            COND_VS: taken = v;
            COND_VC: taken = ~v;
            COND_HI: taken = c & ~z;
            COND_LS: taken = ~c | z;
            COND_GE: taken = (n == v);
            COND_LT: taken = (n != v);
            COND_GT: taken = ~z & (n == v);
            COND_LE: taken = z | (n != v);
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/ctrl_ex.sv
// rtl/ctrl_ex.sv - execute-stage control FSM (writes, memory wait, branch flush)
// Outputs are combinational from state, cnt, the EX instruction and flags.
module ctrl_ex
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] i_ir_ex,
    input  logic [3:0]  i_mem_data_access,
    input  logic [3:0]  i_flags,
    output logic        o_stall,
    output logic        o_mem_re,
    output logic        o_mem_we,
    output logic        o_reg_we,
    output logic [3:0]  o_reg_waddr,
    output logic        o_flags_we,
    output logic        o_pc_load,
    output logic        o_flush
);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    instr_e     instr;
    logic       taken;
    logic       unused_ir;

    assign instr     = decode(i_ir_ex[15:7]);
    assign unused_ir = ^i_ir_ex[6:3];

    cond_eval u_cond_eval (
        .cond  (i_ir_ex[11:8]),
        .flags (i_flags),
        .taken (taken)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_EXEC;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        o_stall     = 1'b0;
        o_mem_re    = 1'b0;
        o_mem_we    = 1'b0;
        o_reg_we    = 1'b0;
        o_reg_waddr = 4'd0;
        o_flags_we  = 1'b0;
        o_pc_load   = 1'b0;
        o_flush     = 1'b0;

        case (state_q)
            S_EXEC: begin
                case (instr)
                    I_ADD: begin
                        o_reg_we    = 1'b1;
                        o_flags_we  = 1'b1;
                        o_reg_waddr = {1'b0, i_ir_ex[2:0]};
                    end
                    I_MOV_IMM: begin
                        o_reg_we    = 1'b1;
                        o_flags_we  = 1'b1;
                        o_reg_waddr = {1'b0, i_ir_ex[10:8]};
                    end
                    I_MOV_REG: begin
                        o_reg_we    = 1'b1;
                        o_reg_waddr = {i_ir_ex[7], i_ir_ex[2:0]};
                    end
                    I_SUB_SP: begin
                        o_reg_we    = 1'b1;
                        o_reg_waddr = SP_IDX;
                    end
                    I_CMP_IMM: o_flags_we = 1'b1;
                    I_LDR, I_STR: begin
                        // N=0 is treated as a one-cycle access.
                        o_stall  = 1'b1;
                        o_mem_re = (instr == I_LDR);
                        o_mem_we = (instr == I_STR);
                        cnt_d    = (i_mem_data_access == 4'd0) ? 4'd0
                                                               : i_mem_data_access - 4'd1;
                        state_d  = S_MEM_WAIT;
                    end
                    I_B, I_BCOND: begin
                        if (instr == I_B || taken) begin
                            o_pc_load = 1'b1;
                            o_flush   = 1'b1;
                            state_d   = S_FLUSH;
                        end
                    end
                    default: ;
                endcase
            end
            S_MEM_WAIT: begin
                // The decode registers are held, so i_ir_ex still names the access.
                o_mem_re = (instr == I_LDR);
                o_mem_we = (instr == I_STR);
                if (cnt_q != 4'd0) begin
                    o_stall = 1'b1;
                    cnt_d   = cnt_q - 4'd1;
                end else begin
                    if (instr == I_LDR) begin
                        o_reg_we    = 1'b1;
                        o_reg_waddr = {1'b0, i_ir_ex[2:0]};
                    end
                    state_d = S_EXEC;
                end
            end
            S_FLUSH: begin
                o_flush = 1'b1;
                state_d = S_EXEC;
            end
            default: state_d = S_EXEC;
        endcase

        if (rst) begin
            o_stall     = 1'b0;
            o_mem_re    = 1'b0;
            o_mem_we    = 1'b0;
            o_reg_we    = 1'b0;
            o_reg_waddr = 4'd0;
            o_flags_we  = 1'b0;
            o_pc_load   = 1'b0;
            o_flush     = 1'b0;
        end
    end

endmodule

// File: tb/tb_ctrl_ex.sv
// tb/tb_ctrl_ex.sv - self-checking bench for ctrl_ex
// Table vectors plus multi-cycle sequences, checked through an expected-value queue.
module tb_ctrl_ex;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] ir;
    logic [3:0]  n;
    logic [3:0]  flags;
    logic        o_stall, o_mem_re, o_mem_we, o_reg_we, o_flags_we, o_pc_load, o_flush;
    logic [3:0]  o_reg_waddr;

    always #5 clk = ~clk;

    ctrl_ex dut (
        .clk               (clk),
        .rst               (rst),
        .i_ir_ex           (ir),
        .i_mem_data_access (n),
        .i_flags           (flags),
        .o_stall           (o_stall),
        .o_mem_re          (o_mem_re),
        .o_mem_we          (o_mem_we),
        .o_reg_we          (o_reg_we),
        .o_reg_waddr       (o_reg_waddr),
        .o_flags_we        (o_flags_we),
        .o_pc_load         (o_pc_load),
        .o_flush           (o_flush)
    );

    typedef struct packed {
        logic       stall;
        logic       re;
        logic       we;
        logic       reg_we;
        logic [3:0] waddr;
        logic       flags_we;
        logic       pc_load;
        logic       flush;
    } out_t;

    typedef struct {
        logic [15:0] ir;
        logic [3:0]  flags;
        out_t        exp;
        string       name;
    } vec_t;

    out_t  act;
    out_t  exp_q[$];
    string name_q[$];
    vec_t  vt[$];
    int    tests = 0;
    int    fails = 0;

    assign act = {o_stall, o_mem_re, o_mem_we, o_reg_we, o_reg_waddr,
                  o_flags_we, o_pc_load, o_flush};

    function automatic out_t mk(input bit st, input bit re, input bit we, input bit rwe,
                                input logic [3:0] wa, input bit fwe, input bit pcl,
                                input bit fl);
        return out_t'({st, re, we, rwe, wa, fwe, pcl, fl});
    endfunction

    task automatic check();
        out_t  e, a;
        string nm;
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL scoreboard_empty: got output %b with no expected value", act);
            return;
        end
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        a  = act;
        if (!e.reg_we) begin
            a.waddr = 4'd0;
            e.waddr = 4'd0;
        end
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got {stall,re,we,reg_we,waddr,flags_we,pc_load,flush}=%b required %b",
                     nm, a, e);
        end
    endtask

    task automatic cyc(input logic r, input logic [15:0] i, input logic [3:0] nn,
                       input logic [3:0] f, input out_t e, input string nm);
        rst   = r;
        ir    = i;
        n     = nn;
        flags = f;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(negedge clk);
        check();
        @(posedge clk);
        #1;
    endtask

    // Expected LDR/STR trace: max(N,1) stall cycles, one extra strobe cycle, LDR writes last.
    task automatic mem_seq(input logic [15:0] i, input logic [3:0] nn, input string nm);
        bit ld;
        int k;
        ld = (i[15:11] == 5'b01101);
        k  = (nn == 4'd0) ? 1 : int'(nn);
        for (int c = 0; c <= k; c++) begin
            cyc(1'b0, i, (c == 0) ? nn : ~nn, 4'h0,
                mk(c < k, ld, !ld, ld && (c == k), {1'b0, i[2:0]}, 0, 0, 0),
                $sformatf("%s_c%0d", nm, c));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; ir = 16'h0; n = 4'h0; flags = 4'h0;

        vt.push_back('{16'h1C8A, 4'h0, mk(0,0,0,1,4'd2,1,0,0),  "add_r2"});
        vt.push_back('{16'h1C8D, 4'hF, mk(0,0,0,1,4'd5,1,0,0),  "add_r5"});
        vt.push_back('{16'h2005, 4'h0, mk(0,0,0,1,4'd0,1,0,0),  "mov_imm_r0"});
        vt.push_back('{16'h2307, 4'h0, mk(0,0,0,1,4'd3,1,0,0),  "mov_imm_r3"});
        vt.push_back('{16'h4687, 4'h0, mk(0,0,0,1,4'd15,0,0,0), "mov_reg_r15"});
        vt.push_back('{16'h4612, 4'h0, mk(0,0,0,1,4'd2,0,0,0),  "mov_reg_r2"});
        vt.push_back('{16'hB082, 4'h0, mk(0,0,0,1,4'd13,0,0,0), "sub_sp"});
        vt.push_back('{16'h2805, 4'h0, mk(0,0,0,0,4'd0,1,0,0),  "cmp_imm"});
        vt.push_back('{16'h0000, 4'hF, mk(0,0,0,0,4'd0,0,0,0),  "nop_zero"});
        vt.push_back('{16'hFFFF, 4'h0, mk(0,0,0,0,4'd0,0,0,0),  "nop_ffff"});
        vt.push_back('{16'h4000, 4'h0, mk(0,0,0,0,4'd0,0,0,0),  "nop_and"});
        vt.push_back('{16'hD005, 4'h0, mk(0,0,0,0,4'd0,0,0,0),  "beq_nt"});
        vt.push_back('{16'hD105, 4'h4, mk(0,0,0,0,4'd0,0,0,0),  "bne_nt"});
        vt.push_back('{16'hDE05, 4'hF, mk(0,0,0,0,4'd0,0,0,0),  "bcond_1110_nt"});
        vt.push_back('{16'hDF05, 4'h0, mk(0,0,0,0,4'd0,0,0,0),  "bcond_1111_nt"});
        vt.push_back('{16'hDC05, 4'h8, mk(0,0,0,0,4'd0,0,0,0),  "bgt_nt"});
        vt.push_back('{16'hDB05, 4'h0, mk(0,0,0,0,4'd0,0,0,0),  "blt_nt"});
        vt.push_back('{16'hD905, 4'h2, mk(0,0,0,0,4'd0,0,0,0),  "bls_nt"});
        vt.push_back('{16'hD405, 4'h0, mk(0,0,0,0,4'd0,0,0,0),  "bmi_nt"});
        vt.push_back('{16'hD005, 4'h4, mk(0,0,0,0,4'd0,0,1,1),  "beq_t"});
        vt.push_back('{16'hE005, 4'h0, mk(0,0,0,0,4'd0,0,1,1),  "b_t"});
        vt.push_back('{16'hD805, 4'h2, mk(0,0,0,0,4'd0,0,1,1),  "bhi_t"});
        vt.push_back('{16'hDD05, 4'h8, mk(0,0,0,0,4'd0,0,1,1),  "ble_t"});
        vt.push_back('{16'hDA05, 4'h9, mk(0,0,0,0,4'd0,0,1,1),  "bge_t"});
        vt.push_back('{16'hD605, 4'h1, mk(0,0,0,0,4'd0,0,1,1),  "bvs_t"});

        @(posedge clk);
        #1;
        cyc(1'b1, 16'h1C8A, 4'h0, 4'h0, mk(0,0,0,0,4'd0,0,0,0), "reset_hold");
        cyc(1'b0, 16'h1C8A, 4'h0, 4'h0, mk(0,0,0,1,4'd2,1,0,0), "add_after_reset");

        foreach (vt[k]) begin
            cyc(1'b0, vt[k].ir, 4'h0, vt[k].flags, vt[k].exp, vt[k].name);
            if (vt[k].exp.pc_load)
                cyc(1'b0, 16'h2005, 4'h0, vt[k].flags, mk(0,0,0,0,4'd0,0,0,1),
                    {vt[k].name, "_flush_mov"});
        end

        mem_seq(16'h6808, 4'd3,  "ldr_n3");
        mem_seq(16'h6008, 4'd0,  "str_n0");
        mem_seq(16'h6008, 4'd1,  "str_n1");
        mem_seq(16'h680D, 4'd2,  "ldr_n2");
        mem_seq(16'h680F, 4'd0,  "ldr_n0");
        mem_seq(16'h6808, 4'd15, "ldr_n15");
        cyc(1'b0, 16'h0000, 4'h0, 4'h0, mk(0,0,0,0,4'd0,0,0,0), "nop_after_mem");

        cyc(1'b0, 16'hD005, 4'h0, 4'h4, mk(0,0,0,0,4'd0,0,1,1), "sq_beq");
        cyc(1'b0, 16'h6808, 4'h3, 4'h4, mk(0,0,0,0,4'd0,0,0,1), "sq_ldr");
        cyc(1'b0, 16'h0000, 4'h0, 4'h0, mk(0,0,0,0,4'd0,0,0,0), "sq_ldr_gone");
        cyc(1'b0, 16'hE005, 4'h0, 4'h0, mk(0,0,0,0,4'd0,0,1,1), "sq_b");
        cyc(1'b0, 16'hE005, 4'h0, 4'h0, mk(0,0,0,0,4'd0,0,0,1), "sq_b_in_flush");
        cyc(1'b0, 16'h2307, 4'h0, 4'h0, mk(0,0,0,1,4'd3,1,0,0), "sq_then_mov");

        cyc(1'b0, 16'h6808, 4'h5, 4'h0, mk(1,1,0,0,4'd0,0,0,0), "rmw_exec");
        cyc(1'b0, 16'h6808, 4'h5, 4'h0, mk(1,1,0,0,4'd0,0,0,0), "rmw_cnt4");
        cyc(1'b0, 16'h6808, 4'h5, 4'h0, mk(1,1,0,0,4'd0,0,0,0), "rmw_cnt3");
        cyc(1'b1, 16'h6808, 4'h5, 4'hF, mk(0,0,0,0,4'd0,0,0,0), "rmw_rst1");
        cyc(1'b1, 16'h6808, 4'h5, 4'hF, mk(0,0,0,0,4'd0,0,0,0), "rmw_rst2");
        cyc(1'b0, 16'h2307, 4'h0, 4'h0, mk(0,0,0,1,4'd3,1,0,0), "rmw_mov");
        cyc(1'b0, 16'h0000, 4'h0, 4'h0, mk(0,0,0,0,4'd0,0,0,0), "rmw_nop");

        cyc(1'b0, 16'hE005, 4'h0, 4'h0, mk(0,0,0,0,4'd0,0,1,1), "rfl_b");
        cyc(1'b1, 16'h2005, 4'h0, 4'h0, mk(0,0,0,0,4'd0,0,0,0), "rfl_rst");
        cyc(1'b0, 16'h2005, 4'h0, 4'h0, mk(0,0,0,1,4'd0,1,0,0), "rfl_mov");

        if (exp_q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL scoreboard_leftover: got %0d entries required 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ctrl_ex.md
CTRL_EX -- requirements
Module: ctrl_ex

Interface
REQ-001 The block SHALL use clock clk and reset rst, synchronous, active-high.
REQ-002 Ports SHALL be:
  clk  in  1  clock
  rst  in  1  synchronous active-high reset
  i_ir_ex  in  16  instruction held in EX by decode stage
  i_mem_data_access  in  4  memory access length N in cycles from decode stage
  i_flags  in  4  {N,Z,C,V} current flags
  o_stall  out  1  hold fetch/decode registers
  o_mem_re  out  1  data memory read strobe
  o_mem_we  out  1  data memory write strobe
  o_reg_we  out  1  register file write enable
  o_reg_waddr  out  4  register file write index
  o_flags_we  out  1  flags register write enable
  o_pc_load  out  1  load PC with branch target
  o_flush  out  1  squash instruction in decode/EX

Function
REQ-003 States SHALL be EXEC, MEM_WAIT and FLUSH, with a 4-bit down-counter cnt.
REQ-004 Decode on i_ir_ex SHALL use: ADD 0001110 (bits 15:9), SUB SP 101100001 (15:7), MOV imm 00100, MOV reg 01000110, LDR 01101, STR 01100, B 11100, B<c> 1101 (15:12), CMP imm 00101; any other encoding is a NOP.
REQ-005 In EXEC, ADD SHALL assert o_reg_we and o_flags_we with waddr {0,ir[2:0]}; MOV imm: reg_we, flags_we, waddr {0,ir[10:8]}; MOV reg: reg_we only, waddr {ir[7],ir[2:0]}; SUB SP: reg_we, waddr 13; CMP: flags_we only.
REQ-006 In EXEC, LDR/STR SHALL assert o_stall and o_mem_re (LDR) or o_mem_we (STR), load cnt with max(N,1)-1 and go to MEM_WAIT; N is sampled only in this cycle.
REQ-007 In MEM_WAIT, the memory strobe SHALL stay asserted; if cnt!=0, o_stall=1 and cnt decrements; if cnt==0, o_stall=0, LDR asserts o_reg_we with waddr {0,ir[2:0]}, and the next state is EXEC.
REQ-008 An LDR/STR SHALL cause exactly max(N,1) stall cycles and max(N,1)+1 strobe cycles.
REQ-009 B SHALL always be taken; B<c> SHALL evaluate cond=ir[11:8] using ARM semantics on i_flags (EQ..LE); cond 1110 and 1111 SHALL be not taken.
REQ-010 A taken branch in EXEC SHALL assert o_pc_load and o_flush for that cycle and go to FLUSH; a not-taken branch SHALL assert nothing.
REQ-011 In FLUSH, o_flush SHALL be 1, the instruction in EX SHALL be squashed, and the next state SHALL be EXEC.
REQ-012 Squashing SHALL mean no reg/flag writes, no memory strobe and no stall, including for a LDR/STR or branch.
REQ-013 i_ir_ex = 0x0000 SHALL act as a NOP.
REQ-014 Outputs SHALL be combinational from state, cnt, i_ir_ex and i_flags; no output may assert in two conflicting roles (mem_re and mem_we never both 1).

Reset
REQ-015 On rst at a clock edge, state SHALL become EXEC and cnt SHALL become 0.
REQ-016 While rst is high, all outputs SHALL be 0.
REQ-017 rst during MEM_WAIT or FLUSH SHALL abort the operation, and the first cycle after reset is an EXEC cycle.

Structure
REQ-018 A shared package cpu_pkg SHALL hold the state enum, opcode match constants, the ALU select encodings, SP index 13, and the cond code constants.
REQ-019 Condition evaluation SHALL be a sub-module cond_eval (in: cond[3:0], flags[3:0]; out: taken).

Verification
REQ-020 Scenario ADD: ir=0x1C8A (ADD r2,r1,#2) -> reg_we=1, flags_we=1, waddr=2, stall=0 in the same cycle.
REQ-021 Scenario LDR: ir=0x6808 with N=3 -> stall=1 for 3 cycles, mem_re=1 for 4 cycles, reg_we=1 with waddr=0 in the 4th cycle only.
REQ-022 Scenario STR: ir=0x6008 with N=0 -> stall=1 for 1 cycle, mem_we=1 for 2 cycles, reg_we=0 throughout.
REQ-023 Scenario B<c>: ir=0xD005 (BEQ) with Z=1 -> pc_load=1 and flush=1, then flush=1 for 1 more cycle; with Z=0 -> no pc_load and no flush.
REQ-024 Scenario FLUSH squash: ir=0x2005 (MOV r0,#5) presented in the FLUSH cycle -> reg_we=0, flags_we=0.
REQ-025 Scenario reset: rst asserted mid-MEM_WAIT (cnt=2) -> all outputs 0 while rst is high; after release, a MOV imm executes with stall=0.
